// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage.
// Defining MULDIV_FAST_MUL_EN replaces the 32-cycle multiply with a single-cycle product.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] RD2_outE,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  counter;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc;
   logic              neg_lo;
   logic              neg_hi;
   logic              div_zero;
   logic              is_div;
   logic [XLEN-1:0]   orig_a;
   logic [XLEN-1:0]   hi_r;
   logic [XLEN-1:0]   lo_r;
   logic              done_r;

   logic              signed_op;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              sign_prod;
   logic              sign_a;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] mul_fix;
   logic [XLEN-1:0]   quot_fix;
   logic [XLEN-1:0]   rem_fix;

   assign signed_op = (op == OP_MULT) || (op == OP_DIV);
   assign abs_a     = (signed_op && SrcAE[XLEN-1])    ? -SrcAE    : SrcAE;
   assign abs_b     = (signed_op && RD2_outE[XLEN-1]) ? -RD2_outE : RD2_outE;
   assign sign_prod = signed_op && (SrcAE[XLEN-1] ^ RD2_outE[XLEN-1]);
   assign sign_a    = signed_op && SrcAE[XLEN-1];

   // Division keeps the partial remainder in acc's upper half and shifts quotient bits into the lower half.
   assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, opnd};
   assign div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];

   assign mul_fix  = neg_lo ? -acc : acc;
   assign quot_fix = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
   assign rem_fix  = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] fast_sprod;
   logic        [2*XLEN-1:0] fast_uprod;
   logic        [2*XLEN-1:0] fast_prod;

   assign fast_sprod = $signed({{XLEN{SrcAE[XLEN-1]}}, SrcAE}) * $signed({{XLEN{RD2_outE[XLEN-1]}}, RD2_outE});
   assign fast_uprod = {{XLEN{1'b0}}, SrcAE} * {{XLEN{1'b0}}, RD2_outE};
   assign fast_prod  = (op == OP_MULT) ? fast_sprod : fast_uprod;
`else
   logic [XLEN:0] mul_sum;

   // Shift-add: multiplier sits in acc's lower half and is consumed LSB first.
   assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         counter  <= '0;
         opnd     <= '0;
         acc      <= '0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
         is_div   <= 1'b0;
         orig_a   <= '0;
         hi_r     <= '0;
         lo_r     <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (flush) begin
            state   <= S_IDLE;
            counter <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     case (op)
                        OP_MTHI: hi_r <= SrcAE;
                        OP_MTLO: lo_r <= SrcAE;
                        OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                           {hi_r, lo_r} <= fast_prod;
                           done_r       <= 1'b1;
`else
                           opnd    <= abs_a;
                           acc     <= {{XLEN{1'b0}}, abs_b};
                           neg_lo  <= sign_prod;
                           is_div  <= 1'b0;
                           counter <= '0;
                           state   <= S_MUL;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                           opnd     <= abs_b;
                           acc      <= {{XLEN{1'b0}}, abs_a};
                           neg_lo   <= sign_prod;
                           neg_hi   <= sign_a;
                           div_zero <= (RD2_outE == '0);
                           orig_a   <= SrcAE;
                           is_div   <= 1'b1;
                           counter  <= '0;
                           state    <= S_DIV;
                        end
                        default: ;
                     endcase
                  end
               end
`ifndef MULDIV_FAST_MUL_EN
               S_MUL: begin
                  acc     <= {mul_sum, acc[XLEN-1:1]};
                  counter <= counter + 1'b1;
                  if (counter == LAST_ITER) state <= S_FIX;
               end
`endif
               S_DIV: begin
                  acc     <= {div_rem, acc[XLEN-2:0], div_ge};
                  counter <= counter + 1'b1;
                  if (counter == LAST_ITER) state <= S_FIX;
               end
               S_FIX: begin
                  // Divide by zero returns all-ones quotient and the untouched dividend.
                  if (!is_div) begin
                     {hi_r, lo_r} <= mul_fix;
                  end else if (div_zero) begin
                     hi_r <= orig_a;
                     lo_r <= {XLEN{1'b1}};
                  end else begin
                     hi_r <= rem_fix;
                     lo_r <= quot_fix;
                  end
                  done_r  <= 1'b1;
                  counter <= '0;
                  state   <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy = (state != S_IDLE);
   assign done = done_r;
   assign HI   = hi_r;
   assign LO   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: multiply, divide, moves, flush and reset.
module tb_muldiv_unit;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_BUSY = 0;
`else
   localparam int MUL_BUSY = 33;
`endif
   localparam int DIV_BUSY = 33;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] SrcAE;
   logic [31:0] RD2_outE;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks;
   int errors;

   muldiv_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .SrcAE    (SrcAE),
      .RD2_outE (RD2_outE),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .HI       (HI),
      .LO       (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one command for exactly one rising edge; returns at the negedge after that edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start    = 1'b1;
      op       = o;
      SrcAE    = a;
      RD2_outE = b;
      @(negedge clk);
      start    = 1'b0;
      op       = OP_NOP;
   endtask

   // Issues a command then samples a fixed 40-cycle window counting busy and done cycles.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cnt, output int done_cnt);
      issue(o, a, b);
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) done_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int bc, dc;
      issue(OP_MTHI, 32'hAAAA5555, 32'h0);
      issue(OP_MULTU, 32'h1234, 32'h5678);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: busy=%b done=%b HI=%h LO=%h, required 0 0 0 0", busy, done, HI, LO);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'h2, bc, dc);
      checks++;
      if (bc !== MUL_BUSY) begin
         errors++;
         $display("[TB] FAIL multu_busy_cycles: got %0d, required %0d", bc, MUL_BUSY);
      end
      checks++;
      if (dc !== 1) begin
         errors++;
         $display("[TB] FAIL multu_done_pulses: got %0d, required 1", dc);
      end
      checks++;
      if (HI !== 32'h1 || LO !== 32'hFFFFFFFE) begin
         errors++;
         $display("[TB] FAIL multu_result: HI=%h LO=%h, required 00000001 fffffffe", HI, LO);
      end
   endtask

   task automatic test_signed();
      int bc, dc;
      run_op(OP_MULT, 32'hFFFFFFFD, 32'h7, bc, dc);
      checks++;
      if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
         errors++;
         $display("[TB] FAIL mult_neg: HI=%h LO=%h, required ffffffff ffffffeb", HI, LO);
      end
      run_op(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, bc, dc);
      checks++;
      if (HI !== 32'h3FFFFFFF || LO !== 32'h00000001 || bc !== MUL_BUSY) begin
         errors++;
         $display("[TB] FAIL mult_maxpos: HI=%h LO=%h busy=%0d, required 3fffffff 00000001 %0d", HI, LO, bc, MUL_BUSY);
      end
      run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, bc, dc);
      checks++;
      if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin
         errors++;
         $display("[TB] FAIL div_neg: HI=%h LO=%h, required ffffffff fffffffd", HI, LO);
      end
      checks++;
      if (bc !== DIV_BUSY || dc !== 1) begin
         errors++;
         $display("[TB] FAIL div_timing: busy=%0d done=%0d, required %0d 1", bc, dc, DIV_BUSY);
      end
      run_op(OP_DIV, 32'h7, 32'hFFFFFFFE, bc, dc);
      checks++;
      if (LO !== 32'hFFFFFFFD || HI !== 32'h1) begin
         errors++;
         $display("[TB] FAIL div_negdivisor: HI=%h LO=%h, required 00000001 fffffffd", HI, LO);
      end
   endtask

   task automatic test_div_boundary();
      int bc, dc;
      run_op(OP_DIVU, 32'd100, 32'h0, bc, dc);
      checks++;
      if (LO !== 32'hFFFFFFFF || HI !== 32'd100 || bc !== DIV_BUSY) begin
         errors++;
         $display("[TB] FAIL divu_by_zero: HI=%h LO=%h busy=%0d, required 00000064 ffffffff %0d", HI, LO, bc, DIV_BUSY);
      end
      run_op(OP_DIV, 32'hFFFFFFFB, 32'h0, bc, dc);
      checks++;
      if (LO !== 32'hFFFFFFFF || HI !== 32'hFFFFFFFB) begin
         errors++;
         $display("[TB] FAIL div_by_zero_signed: HI=%h LO=%h, required fffffffb ffffffff", HI, LO);
      end
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dc);
      checks++;
      if (LO !== 32'h80000000 || HI !== 32'h0) begin
         errors++;
         $display("[TB] FAIL div_overflow: HI=%h LO=%h, required 00000000 80000000", HI, LO);
      end
      run_op(OP_DIVU, 32'hFFFFFFFF, 32'h10, bc, dc);
      checks++;
      if (LO !== 32'h0FFFFFFF || HI !== 32'hF) begin
         errors++;
         $display("[TB] FAIL divu_large: HI=%h LO=%h, required 0000000f 0fffffff", HI, LO);
      end
   endtask

   task automatic test_moves();
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; SrcAE = 32'hDEADBEEF; RD2_outE = 32'h0;
      @(negedge clk);
      checks++;
      if (HI !== 32'hDEADBEEF || LO !== 32'h0FFFFFFF || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mthi: HI=%h LO=%h busy=%b, required deadbeef 0fffffff 0", HI, LO, busy);
      end
      op = OP_MTLO; SrcAE = 32'h12345678;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      checks++;
      if (HI !== 32'hDEADBEEF || LO !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mtlo: HI=%h LO=%h busy=%b done=%b, required deadbeef 12345678 0 0", HI, LO, busy, done);
      end
      @(negedge clk);
      start = 1'b1; op = 3'b111; SrcAE = 32'h55; RD2_outE = 32'h66;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      checks++;
      if (HI !== 32'hDEADBEEF || LO !== 32'h12345678 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL nop_op: HI=%h LO=%h busy=%b, required deadbeef 12345678 0", HI, LO, busy);
      end
   endtask

   task automatic test_busy_ignore();
      int waited;
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      start = 1'b1; op = OP_DIV; SrcAE = 32'd50; RD2_outE = 32'd5;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      waited = 0;
      while (busy === 1'b1 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, waited);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (LO !== 32'd14 || HI !== 32'd2 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_while_busy: HI=%h LO=%h busy=%b, required 00000002 0000000e 0", HI, LO, busy);
      end
   endtask

   task automatic test_flush();
      int dc;
      issue(OP_MTHI, 32'd5, 32'h0);
      issue(OP_MTLO, 32'd6, 32'h0);
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || HI !== 32'd5 || LO !== 32'd6) begin
         errors++;
         $display("[TB] FAIL flush_mid_div: busy=%b HI=%h LO=%h, required 0 00000005 00000006", busy, HI, LO);
      end
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) dc++;
         @(negedge clk);
      end
      checks++;
      if (dc !== 0 || HI !== 32'd5 || LO !== 32'd6) begin
         errors++;
         $display("[TB] FAIL flush_no_done: done=%0d HI=%h LO=%h, required 0 00000005 00000006", dc, HI, LO);
      end
      start = 1'b1; flush = 1'b1; op = OP_DIVU; SrcAE = 32'd9; RD2_outE = 32'd2;
      @(negedge clk);
      op = OP_MTHI;
      @(negedge clk);
      start = 1'b0; flush = 1'b0; op = OP_NOP;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || HI !== 32'd5 || LO !== 32'd6) begin
         errors++;
         $display("[TB] FAIL start_flush_idle: busy=%b done=%b HI=%h LO=%h, required 0 0 00000005 00000006", busy, done, HI, LO);
      end
   endtask

   task automatic test_back_to_back();
      int bc, dc;
      run_op(OP_MULTU, 32'h00010000, 32'h00010000, bc, dc);
      checks++;
      if (HI !== 32'h1 || LO !== 32'h0 || dc !== 1) begin
         errors++;
         $display("[TB] FAIL b2b_multu: HI=%h LO=%h done=%0d, required 00000001 00000000 1", HI, LO, dc);
      end
      run_op(OP_DIVU, 32'd17, 32'd5, bc, dc);
      checks++;
      if (HI !== 32'd2 || LO !== 32'd3 || bc !== DIV_BUSY) begin
         errors++;
         $display("[TB] FAIL b2b_divu: HI=%h LO=%h busy=%0d, required 00000002 00000003 %0d", HI, LO, bc, DIV_BUSY);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      flush    = 1'b0;
      op       = OP_NOP;
      SrcAE    = 32'h0;
      RD2_outE = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_signed();
      test_div_boundary();
      test_moves();
      test_busy_ignore();
      test_flush();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
